// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Default geometry and shared helpers for the multiport regfile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_N_READ  = 2;
    localparam int DEF_N_WRITE = 2;
    localparam int REG0_IDX    = 0;

    // True for the index that is hardwired to zero when that option is on.
    function automatic logic is_hardwired(input bit zero_reg, input int idx);
        return zero_reg && (idx == REG0_IDX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : One busy bit per register, with set/clear and registered lookups.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_READ   = DEF_N_READ,
    parameter int N_WRITE  = DEF_N_WRITE,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_set_en,
    input  logic [ADDR_W-1:0]         i_set_addr,
    input  logic [N_WRITE-1:0]        i_clr_en,
    input  logic [N_WRITE*ADDR_W-1:0] i_clr_addr,
    input  logic [N_READ*ADDR_W-1:0]  i_lookup_addr,
    output logic [N_READ-1:0]         o_busy
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_next;
    logic [N_READ-1:0] r_lookup;

    // Clears are applied first so a same-cycle claim (new producer) wins.
    always_comb begin
        w_busy_next = r_busy;
        for (int w = 0; w < N_WRITE; w++) begin
            if (i_clr_en[w]) begin
                w_busy_next[i_clr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (i_set_en) begin
            w_busy_next[i_set_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            w_busy_next[REG0_IDX] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy   <= '0;
            r_lookup <= '0;
        end else begin
            r_busy <= w_busy_next;
            for (int i = 0; i < N_READ; i++) begin
                r_lookup[i] <= w_busy_next[i_lookup_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign o_busy = r_lookup;

endmodule

`default_nettype wire

// File: rtl/regfile_multiport.sv
// ============================================================================
// Module      : regfile_multiport
// Description : Flip-flop register file, N read / N write ports, write bypass,
//               optional hardwired zero register and a busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int N_READ   = DEF_N_READ,
    parameter int N_WRITE  = DEF_N_WRITE,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_READ*ADDR_W-1:0]  rd_addr,
    output logic [N_READ*DATA_W-1:0]  rd_data,
    output logic [N_READ-1:0]         rd_busy,
    input  logic [N_WRITE-1:0]        wr_en,
    input  logic [N_WRITE*ADDR_W-1:0] wr_addr,
    input  logic [N_WRITE*DATA_W-1:0] wr_data,
    input  logic                      claim_en,
    input  logic [ADDR_W-1:0]         claim_addr
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        r_regs      [DEPTH];
    logic [DATA_W-1:0]        w_regs_next [DEPTH];
    logic [N_READ*DATA_W-1:0] r_rd_data;

    // Ascending port order makes the highest-index write win; reads use the
    // post-write image, which gives the same-edge bypass for free.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            w_regs_next[r] = r_regs[r];
            for (int w = 0; w < N_WRITE; w++) begin
                if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    w_regs_next[r] = wr_data[w*DATA_W +: DATA_W];
                end
            end
            if (is_hardwired(ZERO_REG, r)) begin
                w_regs_next[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                r_regs[r] <= w_regs_next[r];
            end
            for (int i = 0; i < N_READ; i++) begin
                r_rd_data[i*DATA_W +: DATA_W] <= w_regs_next[rd_addr[i*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign rd_data = r_rd_data;

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .N_READ   (N_READ),
        .N_WRITE  (N_WRITE),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .i_set_en      (claim_en),
        .i_set_addr    (claim_addr),
        .i_clr_en      (wr_en),
        .i_clr_addr    (wr_addr),
        .i_lookup_addr (rd_addr),
        .o_busy        (rd_busy)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
// Module      : tb_regfile_multiport
// Description : Self-checking bench for regfile_multiport with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_multiport;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;
    localparam int DEPTH = 32;

    logic             clk;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             claim_en;
    logic [AW-1:0]    claim_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] m_regs [DEPTH];
    logic          m_busy [DEPTH];

    regfile_multiport #(
        .DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .N_WRITE(NW), .ZERO_REG(1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rd_addr    = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        claim_en   = 1'b0;
        claim_addr = '0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    // Apply the current inputs to the model, clock once, compare every read port.
    task automatic tick();
        logic [DW-1:0] exp_d [NR];
        logic          exp_b [NR];
        int a;
        for (int w = 0; w < NW; w++) begin
            a = int'(wr_addr[w*AW +: AW]);
            if (wr_en[w] && a != 0) m_regs[a] = wr_data[w*DW +: DW];
        end
        for (int w = 0; w < NW; w++) begin
            if (wr_en[w]) m_busy[int'(wr_addr[w*AW +: AW])] = 1'b0;
        end
        if (claim_en && claim_addr != '0) m_busy[int'(claim_addr)] = 1'b1;
        for (int i = 0; i < NR; i++) begin
            exp_d[i] = m_regs[int'(rd_addr[i*AW +: AW])];
            exp_b[i] = m_busy[int'(rd_addr[i*AW +: AW])];
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            check($sformatf("rd_data%0d", i), 64'(rd_data[i*DW +: DW]), 64'(exp_d[i]));
            check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(exp_b[i]));
        end
    endtask

    task automatic set_wr(input int p, input int addr, input logic [DW-1:0] data);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = AW'(addr);
        wr_data[p*DW +: DW]  = data;
    endtask

    task automatic set_rd(input int p, input int addr);
        rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    initial begin
        idle();
        model_clear();
        reset = 1'b0;
        #12;
        check("reset_rd_data", 64'(rd_data), 64'd0);
        check("reset_rd_busy", 64'(rd_busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Write r5, read back on both ports.
        idle(); set_wr(0, 5, 32'hDEADBEEF); tick();
        idle(); set_rd(0, 5); set_rd(1, 5); tick();
        check("r5_port0", 64'(rd_data[31:0]),  64'h0000_0000_DEAD_BEEF);
        check("r5_port1", 64'(rd_data[63:32]), 64'h0000_0000_DEAD_BEEF);

        // Same-address double write: port 1 wins for bypass and storage.
        idle(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7); tick();
        check("r7_bypass", 64'(rd_data[31:0]), 64'h22);
        idle(); set_rd(1, 7); tick();
        check("r7_stored", 64'(rd_data[63:32]), 64'h22);

        // Register 0 is hardwired.
        idle(); set_wr(0, 0, 32'hFFFFFFFF); set_rd(0, 0); set_rd(1, 0); tick();
        check("r0_bypass", 64'(rd_data), 64'd0);
        idle(); set_rd(0, 0); claim_en = 1'b1; claim_addr = '0; tick();
        check("r0_after", 64'(rd_data[31:0]), 64'd0);
        check("r0_claim_busy", 64'(rd_busy[0]), 64'd0);

        // Scoreboard claim / clear / claim-beats-write.
        idle(); claim_en = 1'b1; claim_addr = 5'd3; tick();
        idle(); set_rd(0, 3); tick();
        check("r3_busy", 64'(rd_busy[0]), 64'd1);
        idle(); claim_en = 1'b1; claim_addr = 5'd3; set_rd(1, 3); tick();
        check("r3_reclaim", 64'(rd_busy[1]), 64'd1);
        idle(); set_wr(1, 3, 32'h5); tick();
        idle(); set_rd(0, 3); tick();
        check("r3_cleared_busy", 64'(rd_busy[0]), 64'd0);
        check("r3_data", 64'(rd_data[31:0]), 64'h5);
        idle(); claim_en = 1'b1; claim_addr = 5'd3; set_wr(0, 3, 32'h9); set_rd(0, 3); tick();
        check("r3_claim_wins", 64'(rd_busy[0]), 64'd1);
        check("r3_data_bypass", 64'(rd_data[31:0]), 64'h9);

        // Randomized traffic, half of it concentrated on a few addresses.
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < NW; p++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_wr(p, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31), $urandom);
                end
            end
            for (int p = 0; p < NR; p++) begin
                set_rd(p, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            end
            claim_en   = ($urandom_range(0, 3) == 0);
            claim_addr = AW'($urandom_range(0, 7));
            tick();
        end

        // Fill r1..r31, mark some busy, then pulse reset mid-cycle.
        for (int r = 1; r < DEPTH; r += 2) begin
            idle();
            set_wr(0, r, 32'hA500_0000 | 32'(r));
            if (r + 1 < DEPTH) set_wr(1, r + 1, 32'h5A00_0000 | 32'(r + 1));
            claim_en = 1'b1; claim_addr = AW'(r);
            tick();
        end
        idle(); set_rd(0, 1); set_rd(1, 2); claim_en = 1'b1; claim_addr = 5'd2; tick();
        check("pre_reset_nonzero", 64'(rd_data != '0), 64'd1);
        #3;
        set_wr(0, 9, 32'h1234); claim_en = 1'b1; claim_addr = 5'd9;
        reset = 1'b0;
        #1;
        check("async_rd_data", 64'(rd_data), 64'd0);
        check("async_rd_busy", 64'(rd_busy), 64'd0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_rd_data", 64'(rd_data), 64'd0);
        idle();
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < DEPTH; r += 2) begin
            idle(); set_rd(0, r); set_rd(1, r + 1); tick();
        end
        check("post_reset_r9", 64'(m_regs[9]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
